casl_query_ctrl: RTL

CASL_QUERY_CTRL -- requirements
Module: casl_query_ctrl

---
 rtl/casl_query_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/casl_query_ctrl.sv
// Key-load and query sequencer for a logic-locked netlist: fetches a parity-checked key word by word, then runs patterns through the netlist.
// Result valid SETTLE cycles after pattern accept; result held until res_ready, and no new pattern is taken while a result is pending.
module casl_query_ctrl #(
    parameter int KEY_W  = 64,
    parameter int WORD_W = 8,
    parameter int PAT_W  = 36,
    parameter int SETTLE = 2,
    localparam int NWORDS = KEY_W / WORD_W,
    localparam int ADDR_W = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    output logic              kst_req,
    output logic [ADDR_W-1:0] kst_addr,
    input  logic              kst_ack,
    input  logic [WORD_W-1:0] kst_data,
    input  logic              kst_par,
    output logic [KEY_W-1:0]  keyinput,
    output logic              key_valid,
    output logic              key_err,
    input  logic              pat_valid,
    output logic              pat_ready,
    input  logic [PAT_W-1:0]  pat_data,
    output logic [PAT_W-1:0]  lock_in,
    input  logic              lock_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_SETTLE,
        S_RESP,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  idx;
    logic               gap;
    logic [KEY_W-1:0]   key_reg;
    logic [3:0]         cnt;

    logic start_ok;
    logic word_acc;
    logic par_bad;
    logic last_word;
    logic pat_acc;

    assign start_ok  = load_start &
                       ((state == S_IDLE) | (state == S_READY) | (state == S_ERR));
    assign kst_req   = (state == S_LOAD) & ~gap;
    assign kst_addr  = idx;
    assign word_acc  = kst_req & kst_ack;
    assign par_bad   = ^{kst_data, kst_par};
    assign last_word = (idx == ADDR_W'(NWORDS - 1));
    assign pat_ready = (state == S_READY) & ~load_start;
    assign pat_acc   = pat_valid & pat_ready;
    assign res_valid = (state == S_RESP);
    // Only a complete, parity-clean key ever reaches the netlist.
    assign keyinput  = key_valid ? key_reg : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR: begin
                if (load_start) state_nxt = S_LOAD;
            end
            S_READY: begin
                if (load_start)     state_nxt = S_LOAD;
                else if (pat_valid) state_nxt = S_SETTLE;
            end
            S_LOAD: begin
                if (word_acc) begin
                    if (par_bad)        state_nxt = S_ERR;
                    else if (last_word) state_nxt = S_READY;
                end
            end
            S_SETTLE: begin
                if (cnt == 4'd1) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (res_ready) state_nxt = S_READY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            gap       <= 1'b0;
            key_reg   <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            lock_in   <= '0;
            cnt       <= '0;
            res_data  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start_ok) begin
                idx       <= '0;
                gap       <= 1'b0;
                key_reg   <= '0;
                key_valid <= 1'b0;
                key_err   <= 1'b0;
            end else if (word_acc) begin
                // One idle cycle on kst_req between words.
                gap <= 1'b1;
                if (par_bad) begin
                    key_reg <= '0;
                    key_err <= 1'b1;
                    idx     <= '0;
                end else begin
                    key_reg[int'(idx)*WORD_W +: WORD_W] <= kst_data;
                    idx <= idx + 1'b1;
                    if (last_word) key_valid <= 1'b1;
                end
            end else begin
                gap <= 1'b0;
            end

            if (pat_acc) begin
                lock_in <= pat_data;
                cnt     <= 4'(SETTLE);
            end else if (state == S_SETTLE) begin
                cnt <= cnt - 1'b1;
                if (cnt == 4'd1) res_data <= lock_out;
            end
        end
    end

endmodule
